// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus 2-bit BHT, trained from EX, with perf counters.
// Optional macro BP_BHT_EN adds the BHT; without it the BTB taken bit alone is the predictor.
module branch_predictor #(
    parameter int BTB_IDX_W = 6,
    parameter int BHT_IDX_W = 8,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PCF,
    output logic [31:0]      PredNPCF,
    output logic             isBtbTakenF,
    output logic             isBhtTakenF,
    input  logic [31:0]      PCE,
    input  logic [31:0]      BrNPC,
    input  logic             BranchE,
    input  logic             BrTakenE,
    input  logic             isBtbTakenE,
    input  logic             isBhtTakenE,
    output logic             MispredE,
    output logic [31:0]      CorrectNPCE,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [BTB_N-1:0]     btb_valid;
    logic [BTB_N-1:0]     btb_taken;
    logic [TAG_W-1:0]     btb_tag    [BTB_N];
    logic [31:0]          btb_target [BTB_N];

    logic [BTB_IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]     tag_f, tag_e;
    logic                 hit_f, hit_e;
    logic                 pred_taken_f, pred_taken_e;
    logic                 unused_bits;

    assign idx_f = PCF[BTB_IDX_W+1:2];
    assign tag_f = PCF[31:BTB_IDX_W+2];
    assign idx_e = PCE[BTB_IDX_W+1:2];
    assign tag_e = PCE[31:BTB_IDX_W+2];

    assign hit_f       = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
    assign hit_e       = btb_valid[idx_e] && (btb_tag[idx_e] == tag_e);
    assign isBtbTakenF = hit_f & btb_taken[idx_f];

`ifdef BP_BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] bidx_f, bidx_e;

    assign bidx_f       = PCF[BHT_IDX_W+1:2];
    assign bidx_e       = PCE[BHT_IDX_W+1:2];
    assign isBhtTakenF  = bht[bidx_f][1];
    assign pred_taken_e = isBtbTakenE & isBhtTakenE;
    assign unused_bits  = ^{PCF[1:0], PCE[1:0]};

    // Counters reset to weakly not-taken; saturate at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (BranchE) begin
            if (BrTakenE && bht[bidx_e] != 2'b11)
                bht[bidx_e] <= bht[bidx_e] + 2'd1;
            else if (!BrTakenE && bht[bidx_e] != 2'b00)
                bht[bidx_e] <= bht[bidx_e] - 2'd1;
        end
    end
`else
    assign isBhtTakenF  = isBtbTakenF;
    assign pred_taken_e = isBtbTakenE;
    assign unused_bits  = ^{PCF[1:0], PCE[1:0], isBhtTakenE};
`endif

    assign pred_taken_f = isBtbTakenF & isBhtTakenF;
    assign PredNPCF     = pred_taken_f ? btb_target[idx_f] : PCF + 32'd4;

    // A predicted-taken non-branch (stale BTB entry) also flushes, back to PCE+4.
    assign MispredE    = BranchE ? (pred_taken_e != BrTakenE) : pred_taken_e;
    assign CorrectNPCE = (BranchE && BrTakenE) ? BrNPC : PCE + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            btb_taken <= '0;
        end else if (BranchE) begin
            if (BrTakenE) begin
                btb_valid[idx_e] <= 1'b1;
                btb_taken[idx_e] <= 1'b1;
            end else if (hit_e) begin
                btb_taken[idx_e] <= 1'b0;
            end
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (BranchE && BrTakenE) begin
            btb_tag[idx_e]    <= tag_e;
            btb_target[idx_e] <= BrNPC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else begin
            if (BranchE && BranchCnt != '1)
                BranchCnt <= BranchCnt + CNT_W'(1);
            if (MispredE && MispredCnt != '1)
                MispredCnt <= MispredCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, PCE, BrNPC;
    logic        BranchE, BrTakenE, isBtbTakenE, isBhtTakenE;
    logic [31:0] PredNPCF, CorrectNPCE;
    logic        isBtbTakenF, isBhtTakenF, MispredE;
    logic [31:0] BranchCnt, MispredCnt;

    int n_checks = 0;
    int n_errors = 0;

    bit              m_v   [64];
    bit              m_t   [64];
    logic [31:0]     m_tag [64];
    logic [31:0]     m_tgt [64];
    int              m_bht [256];
    longint unsigned m_bc, m_mc;
    localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredNPCF(PredNPCF),
        .isBtbTakenF(isBtbTakenF), .isBhtTakenF(isBhtTakenF),
        .PCE(PCE), .BrNPC(BrNPC), .BranchE(BranchE), .BrTakenE(BrTakenE),
        .isBtbTakenE(isBtbTakenE), .isBhtTakenE(isBhtTakenE),
        .MispredE(MispredE), .CorrectNPCE(CorrectNPCE),
        .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0;
            m_t[i] = 0;
        end
        for (int i = 0; i < 256; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
    endfunction

    function automatic void predict(input logic [31:0] pc, output bit btb_t,
                                    output bit bht_t, output logic [31:0] npc);
        int i;
        i = int'((pc >> 2) % 64);
        btb_t = m_v[i] && (m_tag[i] == (pc >> 8)) && m_t[i];
`ifdef BP_BHT_EN
        bht_t = m_bht[int'((pc >> 2) % 256)] >= 2;
`else
        bht_t = btb_t;
`endif
        npc = (btb_t && bht_t) ? m_tgt[i] : pc + 32'd4;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [31:0] pcf, input logic [31:0] pce, input logic [31:0] npc,
                        input bit br, input bit tk, input bit fb, input bit fh);
        bit          eb, eh, pe, mis;
        logic [31:0] enpc, ecn;
        int          bi, ti;
        PCF = pcf; PCE = pce; BrNPC = npc;
        BranchE = br; BrTakenE = tk; isBtbTakenE = fb; isBhtTakenE = fh;
        #1;
        predict(pcf, eb, eh, enpc);
`ifdef BP_BHT_EN
        pe = fb && fh;
`else
        pe = fb;
`endif
        mis = br ? (pe != tk) : pe;
        ecn = (br && tk) ? npc : pce + 32'd4;
        check("PredNPCF", PredNPCF, enpc);
        check("isBtbTakenF", {31'b0, isBtbTakenF}, {31'b0, eb});
        check("isBhtTakenF", {31'b0, isBhtTakenF}, {31'b0, eh});
        check("MispredE", {31'b0, MispredE}, {31'b0, mis});
        check("CorrectNPCE", CorrectNPCE, ecn);
        check("BranchCnt", BranchCnt, m_bc[31:0]);
        check("MispredCnt", MispredCnt, m_mc[31:0]);
        @(posedge clk);
        if (br) begin
            bi = int'((pce >> 2) % 256);
            ti = int'((pce >> 2) % 64);
            m_bht[bi] = tk ? ((m_bht[bi] < 3) ? m_bht[bi] + 1 : 3)
                           : ((m_bht[bi] > 0) ? m_bht[bi] - 1 : 0);
            if (tk) begin
                m_v[ti] = 1; m_t[ti] = 1; m_tag[ti] = pce >> 8; m_tgt[ti] = npc;
            end else if (m_v[ti] && m_tag[ti] == (pce >> 8)) begin
                m_t[ti] = 0;
            end
        end
        if (br && m_bc < CNT_MAX) m_bc++;
        if (mis && m_mc < CNT_MAX) m_mc++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] bases [4];
        bases[0] = 32'h1000; bases[1] = 32'h1100; bases[2] = 32'h2000; bases[3] = 32'h3FC0;
        return bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 15));
    endfunction

    initial begin
        bit          pb, ph;
        logic [31:0] pn, pce, pcf;
        rst_n = 1'b0;
        PCF = 32'h1000; PCE = '0; BrNPC = '0;
        BranchE = 0; BrTakenE = 0; isBtbTakenE = 0; isBhtTakenE = 0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_PredNPCF", PredNPCF, 32'h1004);
        check("reset_isBtbTakenF", {31'b0, isBtbTakenF}, 32'd0);
        check("reset_isBhtTakenF", {31'b0, isBhtTakenF}, 32'd0);
        check("reset_BranchCnt", BranchCnt, 32'd0);
        check("reset_MispredCnt", MispredCnt, 32'd0);

        // first encounter, loop training, exit
        step(32'h1000, 32'h1000, 32'h0F00, 1, 1, 0, 0);
        step(32'h1000, 32'h0, 32'h0, 0, 0, 0, 0);
        repeat (3) step(32'h1000, 32'h1000, 32'h0F00, 1, 1, 1, 1);
        step(32'h1000, 32'h1000, 32'h0F00, 1, 0, 1, 1);
        step(32'h1000, 32'h1000, 32'h0F00, 1, 0, 0, 1);
        step(32'h1000, 32'h0, 32'h0, 0, 0, 0, 0);
        // aliasing
        step(32'h1000, 32'h1000, 32'h0F00, 1, 1, 0, 0);
        step(32'h1100, 32'h0, 32'h0, 0, 0, 0, 0);
        // stale entry on a non-branch
        step(32'h1000, 32'h1000, 32'h0, 0, 0, 1, 1);
        step(32'h1000, 32'h0, 32'h0, 0, 0, 0, 0);
        // same-cycle write and read
        step(32'h2000, 32'h2000, 32'h3000, 1, 1, 0, 0);
        step(32'h2000, 32'h0, 32'h0, 0, 0, 0, 0);

        // asynchronous reset mid-operation, between clock edges
        PCF = 32'h2000;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_PredNPCF", PredNPCF, 32'h2004);
        check("async_isBtbTakenF", {31'b0, isBtbTakenF}, 32'd0);
        check("async_BranchCnt", BranchCnt, 32'd0);
        check("async_MispredCnt", MispredCnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            pcf = rand_pc();
            pce = rand_pc();
            if ($urandom_range(0, 9) == 0) begin
                step(pcf, pce, rand_pc(), 0, 0, 0, 0);
            end else begin
                predict(pce, pb, ph, pn);
                if ($urandom_range(0, 9) < 3) begin
                    pb = 1'($urandom);
                    ph = 1'($urandom);
                end
                step(pcf, pce, rand_pc(), ($urandom_range(0, 9) < 7), 1'($urandom), pb, ph);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
